branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC and address width in bits.
REQ-002 SHALL have parameter BHT_DEPTH, default 16, number of predictor entries; power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold PC; no fetch advance.
REQ-008 f_is_branch  in  1  predecoded: instruction at pc is a conditional branch.
REQ-009 f_target  in  PC_W  direct target of instruction at pc.
REQ-010 pc  out  PC_W  current fetch PC, registered.
REQ-011 pred_next  out  PC_W  predicted next PC for instruction at pc, combinational.
REQ-012 r_valid  in  1  resolve slot holds a valid instruction.
REQ-013 r_pc  in  PC_W  PC of resolving instruction.
REQ-014 r_branch  in  2  branch class (00 none, 01 reg/flag0-1, 10 flag2, 11 always).
REQ-015 r_func  in  6  function code qualifying r_branch.
REQ-016 r_flags  in  3  ALU flags, bits [2:0].
REQ-017 r_rs_val  in  PC_W  register value for jump-register.
REQ-018 r_target  in  PC_W  direct target address.
REQ-019 r_pred_next  in  PC_W  pred_next carried with this instruction.
REQ-020 redirect  out  1  mispredict; flush younger instructions, combinational.
REQ-021 redirect_pc  out  PC_W  correct next PC, combinational.
REQ-022 branch_cnt, mispred_cnt  out  CNT_W each  resolved-conditional and mispredict counts.

Function
REQ-023 Actual next PC SHALL be: 01/000000 -> r_rs_val; 01/000001 -> r_target if flags[1]; 01/000010 -> r_target if flags[0]; 01/000011 -> r_target if !flags[0]; 10/000000 -> r_target; 10/000001 -> r_target if flags[2]; 10/000010 -> r_target if !flags[2]; 11 -> r_target; otherwise r_pc+1.
REQ-024 An undefined r_func under 01 or 10 SHALL resolve as not taken (r_pc+1), never latch.
REQ-025 Conditional = the five flag-qualified cases of REQ-023; only these update the predictor.
REQ-026 Predictor SHALL be BHT_DEPTH 2-bit saturating counters indexed by PC[log2(BHT_DEPTH)-1:0]; counter msb = predict taken.
REQ-027 pred_next SHALL be f_target if f_is_branch and counter[pc index] msb set, else pc+1; PC arithmetic modulo 2^PC_W.
REQ-028 redirect SHALL equal r_valid and (actual next PC != r_pred_next); redirect_pc SHALL equal actual next PC.
REQ-029 Next pc: redirect -> redirect_pc; else stall -> hold; else pred_next; redirect SHALL override stall.
REQ-030 On r_valid conditional: counter[r_pc index] increments if taken (saturate 11), decrements if not (saturate 00), one edge after resolve.
REQ-031 Same-cycle fetch read and resolve write to one index: fetch SHALL see the pre-update value.
REQ-032 branch_cnt SHALL increment per r_valid conditional; mispred_cnt per redirect; both saturate at all-ones.
REQ-033 r_valid=0 SHALL cause no state change other than PC advance.

Reset
REQ-034 Assertion of rst SHALL immediately force pc=RESET_PC, all counters=01 (weak not-taken), branch_cnt=mispred_cnt=0.
REQ-035 Reset mid-operation SHALL discard any in-flight update; first edge after release fetches from RESET_PC.

Structure
REQ-036 Shared package SHALL hold r_branch class encodings, r_func codes, 2-bit counter constants (SNT/WNT/WT/ST).
REQ-037 Predictor array SHALL be sub-module bht_table (1 combinational read port, 1 synchronous update port, async reset).

Verification
REQ-038 Reset release, stall=0, no branches: pc sequence 0,1,2,3; redirect=0; counters 0.
REQ-039 pc=4 conditional, f_target=0x40, fresh table: pred_next=5; resolve 10/000001 flags=100, r_pred_next=5 -> redirect=1, redirect_pc=0x40, next pc=0x40, mispred_cnt=1.
REQ-040 Same branch taken twice more: counter 01->10->11; next fetch at pc=4 gives pred_next=0x40; taken resolve -> no redirect; four not-taken resolves saturate at 00.
REQ-041 Jump-register 01/000000, r_rs_val=0x123, r_pred_next=r_pc+1, stall=1 -> redirect=1, pc=0x123 next edge despite stall; branch_cnt unchanged.
REQ-042 r_func=0x3F with r_branch=01 -> resolves r_pc+1; no counter update; rst pulse mid-sequence -> pc=RESET_PC, stats 0, all entries 01.
REQ-043 PC_W=8, pc=0xFF, no branch -> pc wraps to 0x00.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predict unit: resolve branch classes,
// function codes and 2-bit saturating counter states.
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_REG    = 2'b01,
    BR_FLAG2  = 2'b10,
    BR_ALWAYS = 2'b11
  } br_class_e;

  // Function codes under BR_REG
  localparam logic [5:0] FN_JR     = 6'h00;
  localparam logic [5:0] FN_F1     = 6'h01;
  localparam logic [5:0] FN_F0     = 6'h02;
  localparam logic [5:0] FN_NF0    = 6'h03;
  // Function codes under BR_FLAG2
  localparam logic [5:0] FN_JMP    = 6'h00;
  localparam logic [5:0] FN_F2     = 6'h01;
  localparam logic [5:0] FN_NF2    = 6'h02;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != CNT_ST) nxt = cnt + 2'd1;
    else if (!taken && cnt != CNT_SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht_table.sv
// Branch history table: DEPTH 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module bht_table
  import branch_predict_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  logic [1:0] r_cnt [DEPTH];

  // Read returns the stored value, so a same-cycle update is not yet visible.
  assign o_rd_cnt = r_cnt[i_rd_idx];

  // NOTE: the table is reset entry-by-entry because every counter must start
  // weak-not-taken; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= CNT_WNT;
    end else if (i_wr_en) begin
      r_cnt[i_wr_idx] <= cnt_next(r_cnt[i_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC generation with a bimodal predictor, branch resolution,
// mispredict redirect and saturating statistics counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              BHT_DEPTH = 16,
  parameter int              CNT_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             f_is_branch,
  input  logic [PC_W-1:0]  f_target,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pred_next,
  input  logic             r_valid,
  input  logic [PC_W-1:0]  r_pc,
  input  logic [1:0]       r_branch,
  input  logic [5:0]       r_func,
  input  logic [2:0]       r_flags,
  input  logic [PC_W-1:0]  r_rs_val,
  input  logic [PC_W-1:0]  r_target,
  input  logic [PC_W-1:0]  r_pred_next,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [PC_W-1:0]  r_fetch_pc;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  logic [1:0]      w_rd_cnt;
  logic [PC_W-1:0] w_actual;
  logic            w_cond;
  logic            w_taken;
  logic            w_upd;

  bht_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst),
    .i_rd_idx   (r_fetch_pc[IDX_W-1:0]),
    .o_rd_cnt   (w_rd_cnt),
    .i_wr_en    (w_upd),
    .i_wr_idx   (r_pc[IDX_W-1:0]),
    .i_wr_taken (w_taken)
  );

  assign pc        = r_fetch_pc;
  assign pred_next = (f_is_branch && w_rd_cnt[1]) ? f_target : r_fetch_pc + PC_W'(1);

  // NOTE: every output of this block gets a default first so an unlisted
  // class/function combination falls through to sequential flow, not a latch.
  always_comb begin
    w_actual = r_pc + PC_W'(1);
    w_cond   = 1'b0;
    w_taken  = 1'b0;
    case (br_class_e'(r_branch))
      BR_REG: begin
        case (r_func)
          FN_JR:   w_actual = r_rs_val;
          FN_F1:   begin w_cond = 1'b1; w_taken = r_flags[1];  end
          FN_F0:   begin w_cond = 1'b1; w_taken = r_flags[0];  end
          FN_NF0:  begin w_cond = 1'b1; w_taken = !r_flags[0]; end
          default: ;
        endcase
      end
      BR_FLAG2: begin
        case (r_func)
          FN_JMP:  w_actual = r_target;
          FN_F2:   begin w_cond = 1'b1; w_taken = r_flags[2];  end
          FN_NF2:  begin w_cond = 1'b1; w_taken = !r_flags[2]; end
          default: ;
        endcase
      end
      BR_ALWAYS: w_actual = r_target;
      default:   ;
    endcase
    if (w_cond && w_taken) w_actual = r_target;
  end

  assign redirect    = r_valid && (w_actual != r_pred_next);
  assign redirect_pc = w_actual;
  assign w_upd       = r_valid && w_cond;

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_br_cnt   <= '0;
      r_mp_cnt   <= '0;
    end else begin
      // A redirect wins over stall: the wrong-path fetch must be abandoned.
      if (redirect)    r_fetch_pc <= w_actual;
      else if (!stall) r_fetch_pc <= pred_next;
      if (w_upd && r_br_cnt != '1)    r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (redirect && r_mp_cnt != '1) r_mp_cnt <= r_mp_cnt + CNT_W'(1);
    end
  end

  assign branch_cnt  = r_br_cnt;
  assign mispred_cnt = r_mp_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios plus randomized traffic
// against a behavioural model; a narrow instance covers PC wrap and saturation.
module tb_branch_predict_unit;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        stall, f_is_branch, r_valid, redirect;
  logic [31:0] f_target, pc, pred_next, r_pc, r_rs_val, r_target, r_pred_next, redirect_pc;
  logic [1:0]  r_branch;
  logic [5:0]  r_func;
  logic [2:0]  r_flags;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        e_rst = 1'b0;
  logic        e_stall, e_fb, e_valid, e_redirect;
  logic [7:0]  e_ftgt, e_pc, e_pred, e_rpc, e_rs, e_tgt, e_rpred, e_rdpc;
  logic [1:0]  e_branch;
  logic [5:0]  e_func;
  logic [2:0]  e_flags, e_bc, e_mc;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .f_is_branch(f_is_branch), .f_target(f_target),
    .pc(pc), .pred_next(pred_next), .r_valid(r_valid), .r_pc(r_pc), .r_branch(r_branch),
    .r_func(r_func), .r_flags(r_flags), .r_rs_val(r_rs_val), .r_target(r_target),
    .r_pred_next(r_pred_next), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predict_unit #(.PC_W(8), .BHT_DEPTH(4), .CNT_W(3), .RESET_PC(8'hFC)) dut8 (
    .clk(clk), .rst(e_rst), .stall(e_stall), .f_is_branch(e_fb), .f_target(e_ftgt),
    .pc(e_pc), .pred_next(e_pred), .r_valid(e_valid), .r_pc(e_rpc), .r_branch(e_branch),
    .r_func(e_func), .r_flags(e_flags), .r_rs_val(e_rs), .r_target(e_tgt),
    .r_pred_next(e_rpred), .redirect(e_redirect), .redirect_pc(e_rdpc),
    .branch_cnt(e_bc), .mispred_cnt(e_mc)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: fetch PC, one saturating 0..3 strength per table slot, stats.
  logic [31:0] m_pc;
  int          m_bht [DEPTH];
  int          m_bc, m_mc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Where control goes after the resolving instruction, read straight off the ISA rules.
  function automatic logic [31:0] ref_next(input logic [1:0] br, input logic [5:0] fn,
                                           input logic [2:0] fl, input logic [31:0] rpc,
                                           input logic [31:0] rs, input logic [31:0] tgt,
                                           output bit cond, output bit taken);
    logic [31:0] fall;
    fall  = rpc + 32'd1;
    cond  = 0;
    taken = 0;
    if (br == 2'b11) return tgt;
    if (br == 2'b01 && fn == 6'd0) return rs;
    if (br == 2'b10 && fn == 6'd0) return tgt;
    if (br == 2'b01 && fn == 6'd1) begin cond = 1; taken = fl[1];  end
    if (br == 2'b01 && fn == 6'd2) begin cond = 1; taken = fl[0];  end
    if (br == 2'b01 && fn == 6'd3) begin cond = 1; taken = !fl[0]; end
    if (br == 2'b10 && fn == 6'd1) begin cond = 1; taken = fl[2];  end
    if (br == 2'b10 && fn == 6'd2) begin cond = 1; taken = !fl[2]; end
    return taken ? tgt : fall;
  endfunction

  task automatic idle();
    stall = 0; f_is_branch = 0; f_target = 0; r_valid = 0; r_pc = 0; r_branch = 0;
    r_func = 0; r_flags = 0; r_rs_val = 0; r_target = 0; r_pred_next = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  // Entered at a falling edge; reset is held across one rising edge.
  task automatic do_reset();
    idle();
    rst = 0;
    #1;
    check("rst_pc", pc, 0);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  // Inputs are already driven at a falling edge; check, clock, check, return at next falling edge.
  task automatic cycle(input string tag);
    bit          cond, taken, exp_redir;
    logic [31:0] actual, exp_pred;
    int          fi, ri;
    #1;
    actual    = ref_next(r_branch, r_func, r_flags, r_pc, r_rs_val, r_target, cond, taken);
    fi        = int'(m_pc % DEPTH);
    exp_pred  = (f_is_branch && m_bht[fi] >= 2) ? f_target : m_pc + 32'd1;
    exp_redir = r_valid && (actual != r_pred_next);
    check({tag, ".pred_next"}, pred_next, exp_pred);
    check({tag, ".redirect"}, redirect, exp_redir);
    check({tag, ".redirect_pc"}, redirect_pc, actual);
    if (exp_redir)   m_pc = actual;
    else if (!stall) m_pc = exp_pred;
    if (r_valid && cond) begin
      ri = int'(r_pc % DEPTH);
      m_bht[ri] = taken ? ((m_bht[ri] == 3) ? 3 : m_bht[ri] + 1)
                        : ((m_bht[ri] == 0) ? 0 : m_bht[ri] - 1);
      if (m_bc < 65535) m_bc++;
    end
    if (exp_redir && m_mc < 65535) m_mc++;
    @(posedge clk);
    #1;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".branch_cnt"}, branch_cnt, m_bc);
    check({tag, ".mispred_cnt"}, mispred_cnt, m_mc);
    @(negedge clk);
  endtask

  task automatic resolve(input logic [31:0] rpc, input logic [1:0] br, input logic [5:0] fn,
                         input logic [2:0] fl, input logic [31:0] tgt, input logic [31:0] rpred);
    r_valid = 1; r_pc = rpc; r_branch = br; r_func = fn; r_flags = fl;
    r_target = tgt; r_pred_next = rpred;
  endtask

  task automatic steer_to(input logic [31:0] addr);
    idle();
    resolve(32'h200, 2'b01, 6'd0, 3'b000, 32'd0, 32'h201);
    r_rs_val = addr;
    cycle("steer");
  endtask

  initial begin
    idle();
    e_stall = 0; e_fb = 0; e_ftgt = 0; e_valid = 0; e_rpc = 0; e_branch = 0;
    e_func = 0; e_flags = 0; e_rs = 0; e_tgt = 0; e_rpred = 0;
    @(negedge clk);
    do_reset();

    // Straight-line fetch 0 -> 1 -> 2 -> 3 -> 4
    repeat (4) begin idle(); cycle("seq"); end

    // Fresh table predicts not-taken at pc=4; a taken flag2 branch redirects to 0x40
    idle();
    f_is_branch = 1; f_target = 32'h40;
    resolve(32'd4, 2'b10, 6'd1, 3'b100, 32'h40, 32'd5);
    cycle("first_mispredict");

    idle();
    resolve(32'd4, 2'b10, 6'd1, 3'b100, 32'h40, 32'h40);
    cycle("train_taken");
    steer_to(32'd4);
    idle();
    f_is_branch = 1; f_target = 32'h40;
    resolve(32'd4, 2'b10, 6'd1, 3'b100, 32'h40, 32'h40);
    cycle("predict_taken");
    repeat (4) begin
      idle();
      resolve(32'd4, 2'b10, 6'd1, 3'b000, 32'h40, 32'd5);
      cycle("train_not_taken");
    end
    steer_to(32'd4);
    idle();
    f_is_branch = 1; f_target = 32'h40;
    cycle("saturated_low");

    // Jump-register overrides stall; not a conditional
    idle();
    stall = 1;
    resolve(32'h10, 2'b01, 6'd0, 3'b000, 32'd0, 32'h11);
    r_rs_val = 32'h123;
    cycle("jr_stall");

    // Undefined function code falls through without training
    idle();
    resolve(32'd4, 2'b01, 6'h3F, 3'b111, 32'h40, 32'd5);
    cycle("undef_func");

    // Reset with a taken update in flight: the update must be discarded
    idle();
    resolve(32'd4, 2'b10, 6'd1, 3'b100, 32'h40, 32'd5);
    #1;
    rst = 0;
    #1;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_branch_cnt", branch_cnt, 0);
    check("mid_rst_mispred_cnt", mispred_cnt, 0);
    model_reset();
    idle();
    @(negedge clk);
    rst = 1;
    repeat (6) begin
      idle();
      f_is_branch = 1; f_target = 32'h80;
      cycle("post_rst_weak");
    end

    // Randomized traffic with small PCs so table slots alias and train
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        stall       = ($urandom_range(0, 3) == 0);
        f_is_branch = $urandom_range(0, 1) == 1;
        f_target    = 32'($urandom_range(0, 63));
        r_valid     = ($urandom_range(0, 3) != 0);
        r_pc        = 32'($urandom_range(0, 63));
        r_branch    = 2'($urandom_range(0, 3));
        r_func      = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 4));
        r_flags     = 3'($urandom_range(0, 7));
        r_rs_val    = $urandom;
        r_target    = 32'($urandom_range(0, 63));
        r_pred_next = $urandom_range(0, 1) ? r_pc + 32'd1 : r_target;
        cycle("rand");
      end
    end
    idle();

    // Narrow instance: PC wraps modulo 2^8 and stats saturate at 3'b111
    e_rst = 0;
    #1;
    check("w8_rst_pc", e_pc, 8'hFC);
    check("w8_rst_cnt", {e_bc, e_mc}, 0);
    @(negedge clk);
    e_rst = 1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("w8_wrap_pc", e_pc, 8'(8'hFC + k));
      @(negedge clk);
    end
    e_stall = 1; e_valid = 1; e_branch = 2'b10; e_func = 6'd1; e_flags = 3'b100;
    e_rpc = 8'h00; e_tgt = 8'h20; e_rpred = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      #1;
      check("w8_redirect", e_redirect, 1);
      check("w8_redirect_pc", e_rdpc, 8'h20);
      @(posedge clk);
      #1;
      check("w8_pc", e_pc, 8'h20);
      check("w8_branch_cnt", e_bc, (k > 7) ? 7 : k);
      check("w8_mispred_cnt", e_mc, (k > 7) ? 7 : k);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
